// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and timing helpers for the VGA timing generator.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_640 = 640;
    localparam int unsigned H_FP_640     = 16;
    localparam int unsigned H_SYNC_640   = 96;
    localparam int unsigned H_BP_640     = 48;
    localparam int unsigned V_ACTIVE_480 = 480;
    localparam int unsigned V_FP_480     = 10;
    localparam int unsigned V_SYNC_480   = 2;
    localparam int unsigned V_BP_480     = 33;

    localparam bit SYNC_ACTIVE_LOW = 1'b0;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned H_TOTAL_640 = axis_total(H_ACTIVE_640, H_FP_640, H_SYNC_640, H_BP_640);
    localparam int unsigned V_TOTAL_480 = axis_total(V_ACTIVE_480, V_FP_480, V_SYNC_480, V_BP_480);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync/active decode of the next count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = H_ACTIVE_640,
    parameter int unsigned FP     = H_FP_640,
    parameter int unsigned SYNC   = H_SYNC_640,
    parameter int unsigned BP     = H_BP_640,
    parameter int unsigned CNT_W  = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             advance_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic             wrap_o,
    output logic             sync_act_o,
    output logic             active_o
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC);
    localparam logic [CNT_W-1:0] ACT_LIM = CNT_W'(ACTIVE);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign wrap_o = advance_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (advance_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decode looks at the next count so the parent can register it alongside cnt_q.
    assign cnt_o      = cnt_q;
    assign cnt_nxt_o  = cnt_d;
    assign sync_act_o = (cnt_d >= SYNC_LO) && (cnt_d < SYNC_HI);
    assign active_o   = cnt_d < ACT_LIM;

    always_ff @(posedge clk_i) begin
        assert (ACTIVE >= 1 && FP >= 1 && SYNC >= 1 && BP >= 1)
            else $error("vga_axis_counter: every timing parameter must be >= 1");
        assert (TOTAL <= (32'd1 << CNT_W))
            else $error("vga_axis_counter: CNT_W too narrow for axis total");
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: registered, mutually aligned syncs, data-enable, coordinates and strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_640,
    parameter int unsigned H_FP     = H_FP_640,
    parameter int unsigned H_SYNC   = H_SYNC_640,
    parameter int unsigned H_BP     = H_BP_640,
    parameter int unsigned V_ACTIVE = V_ACTIVE_480,
    parameter int unsigned V_FP     = V_FP_480,
    parameter int unsigned V_SYNC   = V_SYNC_480,
    parameter int unsigned V_BP     = V_BP_480,
    parameter bit          HS_POL   = SYNC_ACTIVE_LOW,
    parameter bit          VS_POL   = SYNC_ACTIVE_LOW,
    parameter int unsigned CNT_W    = 10
) (
    input  logic             pixel_clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic [CNT_W-1:0] px_x,
    output logic [CNT_W-1:0] px_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] H_LAST_ACT = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST_ACT = CNT_W'(V_ACTIVE - 1);

    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             h_wrap, v_wrap;
    logic             h_sync, v_sync;
    logic             h_active, v_active;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk_i      (pixel_clk),
        .rst_ni     (rst_n),
        .advance_i  (en),
        .cnt_o      (px_x),
        .cnt_nxt_o  (h_nxt),
        .wrap_o     (h_wrap),
        .sync_act_o (h_sync),
        .active_o   (h_active)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk_i      (pixel_clk),
        .rst_ni     (rst_n),
        .advance_i  (en && h_wrap),
        .cnt_o      (px_y),
        .cnt_nxt_o  (v_nxt),
        .wrap_o     (v_wrap),
        .sync_act_o (v_sync),
        .active_o   (v_active)
    );

    logic hs_q, vs_q, de_q, ls_q, fs_q, fe_q;

    // A wrap on this edge means the counters land on x==0 (and y==0 for v_wrap) next.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            fe_q <= 1'b0;
        end else if (en) begin
            hs_q <= h_sync ? HS_POL : ~HS_POL;
            vs_q <= v_sync ? VS_POL : ~VS_POL;
            de_q <= h_active && v_active;
            ls_q <= h_wrap;
            fs_q <= v_wrap;
            fe_q <= (h_nxt == H_LAST_ACT) && (v_nxt == V_LAST_ACT);
        end
    end

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_de      = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_end   = fe_q;

endmodule
